load_store_unit: RTL

//  Memory-stage initiator for the data-memory word port: turns pipeline load/store ops into word requests.

---
 rtl/load_store_unit_pkg.sv | 61 ++++++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit_align.sv | 40 ++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
// LSU_MISALIGN_SPLIT_EN adds the second-request states used for split accesses.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [BE_W-1:0] LANE_MASK_B = 4'b0001;
  localparam logic [BE_W-1:0] LANE_MASK_H = 4'b0011;
  localparam logic [BE_W-1:0] LANE_MASK_W = 4'b1111;

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ0  = 3'd1,
    LSU_WAIT0 = 3'd2,
    LSU_REQ1  = 3'd3,
    LSU_WAIT1 = 3'd4,
    LSU_DONE  = 3'd5
  } lsu_state_t;
`else
  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ0  = 3'd1,
    LSU_WAIT0 = 3'd2,
    LSU_DONE  = 3'd5
  } lsu_state_t;
`endif

  function automatic logic [BE_W-1:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return LANE_MASK_B;
      2'b01:   return LANE_MASK_H;
      default: return LANE_MASK_W;
    endcase
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return ~we;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return (off == 2'd3);
      2'b10:   return (off != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory word port between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, shifted store data, and load extract/merge/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic              hi_sel_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rdata0_i,
  input  logic [DATA_W-1:0] rdata1_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [4:0]          shamt;
  logic [2*BE_W-1:0]   be_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [DATA_W-1:0]   ld_raw;

  // Double-width shifts: the upper half is the spill into the next word.
  always_comb begin
    shamt      = {off_i, 3'b000};
    be_wide    = {{BE_W{1'b0}}, lane_mask(funct3_i)} << off_i;
    wdata_wide = {{DATA_W{1'b0}}, store_data_i} << shamt;
    be_o       = hi_sel_i ? be_wide[2*BE_W-1:BE_W] : be_wide[BE_W-1:0];
    wdata_o    = hi_sel_i ? wdata_wide[2*DATA_W-1:DATA_W] : wdata_wide[DATA_W-1:0];
    ld_raw     = DATA_W'({rdata1_i, rdata0_i} >> shamt);

    ld_data_o = ld_raw;
    case (funct3_i)
      LSU_B:   ld_data_o = {{24{ld_raw[7]}}, ld_raw[7:0]};
      LSU_H:   ld_data_o = {{16{ld_raw[15]}}, ld_raw[15:0]};
      LSU_BU:  ld_data_o = {24'd0, ld_raw[7:0]};
      LSU_HU:  ld_data_o = {16'd0, ld_raw[15:0]};
      default: ld_data_o = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: captures a pipeline op, drives the data-memory word port, stalls until done.
// LSU_MISALIGN_SPLIT_EN: misaligned H/W accesses become two word requests instead of an access fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              stall,
  output logic              access_fault,
  load_store_unit_if.master dmem
);

  lsu_state_t        state_q, state_d, after_first;
  logic              we_q, fault_q, fault_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q, word_addr, req_addr;
  logic [DATA_W-1:0] sdata_q, rdata0_q, rdata1_q;
  logic              cap_en, rd0_en, rd1_en;
  logic              in_req, in_done, hi_sel;
  logic [BE_W-1:0]   align_be;
  logic [DATA_W-1:0] align_wdata, align_ld;

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic split_q, split_d;

  assign fault_d     = ~f3_legal(funct3, mem_write);
  assign split_d     = ~fault_d & misaligned(funct3, addr[1:0]);
  assign after_first = split_q ? LSU_REQ1 : LSU_DONE;
  assign hi_sel      = (state_q == LSU_REQ1);
  assign in_req      = (state_q == LSU_REQ0) | (state_q == LSU_REQ1);
  assign req_addr    = hi_sel ? word_addr + ADDR_W'(4) : word_addr;
`else
  assign fault_d     = ~f3_legal(funct3, mem_write) | misaligned(funct3, addr[1:0]);
  assign after_first = LSU_DONE;
  assign hi_sel      = 1'b0;
  assign in_req      = (state_q == LSU_REQ0);
  assign req_addr    = word_addr;
  assign rd1_en      = 1'b0;
  assign rdata1_q    = '0;
`endif

  // Next-state and handshake control.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    rd0_en  = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    rd1_en  = 1'b0;
`endif
    stall   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (mem_read | mem_write) begin
          stall   = 1'b1;
          cap_en  = 1'b1;
          state_d = fault_d ? LSU_DONE : LSU_REQ0;
        end
      end
      LSU_REQ0: begin
        stall = 1'b1;
        if (dmem.dmem_gnt) state_d = we_q ? after_first : LSU_WAIT0;
      end
      LSU_WAIT0: begin
        stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          rd0_en  = 1'b1;
          state_d = after_first;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      LSU_REQ1: begin
        stall = 1'b1;
        if (dmem.dmem_gnt) state_d = we_q ? LSU_DONE : LSU_WAIT1;
      end
      LSU_WAIT1: begin
        stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          rd1_en  = 1'b1;
          state_d = LSU_DONE;
        end
      end
`endif
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      rdata0_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      rdata1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        we_q    <= mem_write;
        fault_q <= fault_d;
        f3_q    <= funct3;
        addr_q  <= addr;
        sdata_q <= store_data;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_q <= split_d;
`endif
      end
      if (rd0_en) rdata0_q <= dmem.dmem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (rd1_en) rdata1_q <= dmem.dmem_rdata;
`endif
    end
  end

  lsu_align u_align (
    .funct3_i     (f3_q),
    .off_i        (addr_q[1:0]),
    .hi_sel_i     (hi_sel),
    .store_data_i (sdata_q),
    .rdata0_i     (rdata0_q),
    .rdata1_i     (rdata1_q),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .ld_data_o    (align_ld)
  );

  // Bus fields read as zero whenever no request is outstanding.
  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req & we_q;
  assign dmem.dmem_addr  = in_req ? req_addr : '0;
  assign dmem.dmem_be    = in_req ? align_be : '0;
  assign dmem.dmem_wdata = (in_req & we_q) ? align_wdata : '0;

  assign in_done      = (state_q == LSU_DONE);
  assign ld_valid     = in_done & ~we_q & ~fault_q;
  assign access_fault = in_done & fault_q;
  assign ld_data      = ld_valid ? align_ld : '0;

endmodule
